pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage core. It generates the hold, flush and bubble controls for the PC, IF/ID and ID/EXE pipeline registers from load-use hazards, taken branches and memory stalls. It also serialises CSR instructions by draining older instructions before issue, and sequences trap redirects through a single-cycle `CSR_reset` pulse. It sits beside the decode stage and drives the `Control_flush`, `CSR_stall` and `CSR_reset` inputs of the ID/EXE register.

---
 rtl/pipeline_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and sequencing controller for the five-stage core. Produces the
//   hold / flush / bubble controls for the PC, IF/ID and ID/EXE registers from
//   load-use hazards, taken branches and memory stalls. It also serialises CSR
//   instructions by draining older work, and sequences trap redirects.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   ID_valid, ID_is_csr     : ID instruction present / is a CSR access
//   ID_rs{1,2}_addr         : ID source register addresses
//   ID_uses_rs{1,2}         : source actually read
//   ID_src{1,2}_f           : source comes from the FP register file
//   EXE_MemRead             : EXE instruction is a load
//   EXE_write_addr, EXE_dst_f : EXE destination and its register file
//   branch_taken            : EXE resolved a redirect
//   trap_req                : level trap request, held until CSR_reset
//   im_stall, dm_stall      : memory waits
//   PC_stall, IFID_stall    : hold PC / IF/ID
//   IFID_flush              : clear IF/ID
//   Control_flush           : bubble into ID/EXE
//   CSR_stall               : CSR drain in progress
//   CSR_reset               : one-cycle trap redirect / trap acknowledge
//   stall_cycles            : number of cycles with PC_stall=1 (wraps)

module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_valid,
    input  logic        ID_is_csr,
    input  logic [4:0]  ID_rs1_addr,
    input  logic [4:0]  ID_rs2_addr,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic        ID_src1_f,
    input  logic        ID_src2_f,
    input  logic        EXE_MemRead,
    input  logic [4:0]  EXE_write_addr,
    input  logic        EXE_dst_f,
    input  logic        branch_taken,
    input  logic        trap_req,
    input  logic        im_stall,
    input  logic        dm_stall,
    output logic        PC_stall,
    output logic        IFID_stall,
    output logic        IFID_flush,
    output logic        Control_flush,
    output logic        CSR_stall,
    output logic        CSR_reset,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic mstall;
    logic exe_dst_is_x0;
    logic src1_hit, src2_hit;
    logic lu;

    // Hazard detection. Integer x0 is hard-wired zero and never creates a
    // dependency; FP f0 is an ordinary register and does.
    always_comb begin
        mstall        = im_stall | dm_stall;
        exe_dst_is_x0 = (EXE_write_addr == 5'd0) && !EXE_dst_f;
        src1_hit      = ID_uses_rs1 && (ID_rs1_addr == EXE_write_addr)
                        && (ID_src1_f == EXE_dst_f) && !exe_dst_is_x0;
        src2_hit      = ID_uses_rs2 && (ID_rs2_addr == EXE_write_addr)
                        && (ID_src2_f == EXE_dst_f) && !exe_dst_is_x0;
        lu            = ID_valid && EXE_MemRead && (src1_hit || src2_hit);
    end

    // Next state and controls, priority: reset, mstall, trap, branch, FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PC_stall      = 1'b0;
        IFID_stall    = 1'b0;
        IFID_flush    = 1'b0;
        Control_flush = 1'b0;
        CSR_stall     = 1'b0;
        CSR_reset     = 1'b0;

        if (reset) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (mstall) begin
            // Everything freezes; a drain keeps its bubble asserted.
            PC_stall   = 1'b1;
            IFID_stall = 1'b1;
            CSR_stall  = (state_q == ST_DRAIN);
        end else if (trap_req) begin
            CSR_reset  = 1'b1;
            IFID_flush = 1'b1;
            state_d    = ST_RUN;
            cnt_d      = '0;
        end else if (branch_taken) begin
            // A CSR being drained or issued is on the wrong path.
            IFID_flush    = 1'b1;
            Control_flush = 1'b1;
            state_d       = ST_RUN;
            cnt_d         = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ID_valid && ID_is_csr) begin
                        CSR_stall  = 1'b1;
                        PC_stall   = 1'b1;
                        IFID_stall = 1'b1;
                        if (DRAIN_CYCLES == 1) begin
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_DRAIN;
                            cnt_d   = DRAIN_LOAD;
                        end
                    end else if (lu) begin
                        PC_stall      = 1'b1;
                        IFID_stall    = 1'b1;
                        Control_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    CSR_stall  = 1'b1;
                    PC_stall   = 1'b1;
                    IFID_stall = 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_ISSUE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_ISSUE: begin
                    // The CSR check is skipped here so the issuing CSR does
                    // not immediately re-trigger a drain of itself.
                    if (lu) begin
                        PC_stall      = 1'b1;
                        IFID_stall    = 1'b1;
                        Control_flush = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, PC_stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // The counter output also reads zero during the reset cycle.
    assign stall_cycles = reset ? '0 : stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int unsigned D = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ID_valid = 1'b0, ID_is_csr = 1'b0;
    logic [4:0]  ID_rs1_addr = '0, ID_rs2_addr = '0;
    logic        ID_uses_rs1 = 1'b0, ID_uses_rs2 = 1'b0;
    logic        ID_src1_f = 1'b0, ID_src2_f = 1'b0;
    logic        EXE_MemRead = 1'b0;
    logic [4:0]  EXE_write_addr = '0;
    logic        EXE_dst_f = 1'b0;
    logic        branch_taken = 1'b0, trap_req = 1'b0;
    logic        im_stall = 1'b0, dm_stall = 1'b0;
    logic        PC_stall, IFID_stall, IFID_flush, Control_flush;
    logic        CSR_stall, CSR_reset;
    logic [31:0] stall_cycles;

    pipeline_ctrl #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .ID_valid(ID_valid), .ID_is_csr(ID_is_csr),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_src1_f(ID_src1_f), .ID_src2_f(ID_src2_f),
        .EXE_MemRead(EXE_MemRead), .EXE_write_addr(EXE_write_addr),
        .EXE_dst_f(EXE_dst_f), .branch_taken(branch_taken),
        .trap_req(trap_req), .im_stall(im_stall), .dm_stall(dm_stall),
        .PC_stall(PC_stall), .IFID_stall(IFID_stall),
        .IFID_flush(IFID_flush), .Control_flush(Control_flush),
        .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, vld, csr;
        logic [4:0] rs1, rs2;
        logic       u1, u2, f1, f2, ld;
        logic [4:0] wa;
        logic       df, br, trap, ims, dms;
    } stim_t;

    // ctrl = {PC_stall, IFID_stall, IFID_flush, Control_flush, CSR_stall, CSR_reset}
    typedef struct packed {
        logic [5:0]  ctrl;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_no = 0;

    // Reference model: remaining drain cycles plus an "issue pending" flag.
    int          m_left = 0;
    bit          m_issue = 0;
    logic [31:0] m_count = '0;

    function automatic bit src_dep(input logic u, input logic [4:0] a,
                                   input logic f, input logic [4:0] wa,
                                   input logic df);
        if (!u) return 0;
        if (!df && wa == 0) return 0;
        return (a == wa) && (f == df);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic cycle(input stim_t s);
        exp_t e;
        bit pc, ifs, ifl, cfl, cst, crs, ms, lu;
        reset = s.rst; ID_valid = s.vld; ID_is_csr = s.csr;
        ID_rs1_addr = s.rs1; ID_rs2_addr = s.rs2;
        ID_uses_rs1 = s.u1; ID_uses_rs2 = s.u2;
        ID_src1_f = s.f1; ID_src2_f = s.f2;
        EXE_MemRead = s.ld; EXE_write_addr = s.wa; EXE_dst_f = s.df;
        branch_taken = s.br; trap_req = s.trap;
        im_stall = s.ims; dm_stall = s.dms;

        {pc, ifs, ifl, cfl, cst, crs} = '0;
        ms = s.ims | s.dms;
        lu = s.vld && s.ld && (src_dep(s.u1, s.rs1, s.f1, s.wa, s.df) ||
                               src_dep(s.u2, s.rs2, s.f2, s.wa, s.df));
        e.cnt = s.rst ? 32'd0 : m_count;
        if (s.rst) begin
            m_left = 0; m_issue = 0; m_count = '0;
        end else begin
            if (ms) begin
                pc = 1; ifs = 1; cst = (m_left > 0);
            end else if (s.trap) begin
                crs = 1; ifl = 1; m_left = 0; m_issue = 0;
            end else if (s.br) begin
                ifl = 1; cfl = 1; m_left = 0; m_issue = 0;
            end else if (m_left > 0) begin
                cst = 1; pc = 1; ifs = 1;
                m_left--;
                if (m_left == 0) m_issue = 1;
            end else if (m_issue) begin
                if (lu) begin pc = 1; ifs = 1; cfl = 1; end
                else m_issue = 0;
            end else if (s.vld && s.csr) begin
                cst = 1; pc = 1; ifs = 1;
                m_left = int'(D) - 1;
                if (m_left == 0) m_issue = 1;
            end else if (lu) begin
                pc = 1; ifs = 1; cfl = 1;
            end
            if (pc) m_count = m_count + 32'd1;
        end
        e.ctrl = {pc, ifs, ifl, cfl, cst, crs};
        e.cyc = cyc_no;
        sb.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a fresh control word.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e = sb.pop_front();
            act = {PC_stall, IFID_stall, IFID_flush, Control_flush, CSR_stall, CSR_reset};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got=%b exp=%b", e.cyc, act, e.ctrl);
            end
            checks++;
            if (stall_cycles !== e.cnt) begin
                errors++;
                $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d",
                         e.cyc, stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        @(posedge clk);
        #1;
        // reset
        s = idle(); s.rst = 1;
        cycle(s); cycle(s);

        // load-use on x5, then the x0 case that must not stall
        s = idle(); s.vld = 1; s.ld = 1; s.wa = 5; s.rs1 = 5; s.u1 = 1;
        cycle(s);
        cycle(idle());
        s.wa = 0; s.rs1 = 0;
        cycle(s);
        // FP f0 does create a dependency
        s.df = 1; s.f1 = 1;
        cycle(s);
        cycle(idle());

        // CSR drain, plain
        s = idle(); s.vld = 1; s.csr = 1;
        repeat (D + 1) cycle(s);
        cycle(idle());

        // CSR drain with two dm_stall cycles in the middle
        s = idle(); s.vld = 1; s.csr = 1;
        cycle(s);
        s.dms = 1; cycle(s); cycle(s);
        s.dms = 0;
        repeat (D) cycle(s);
        cycle(idle());

        // branch in the second drain cycle
        s = idle(); s.vld = 1; s.csr = 1;
        cycle(s); cycle(s);
        s.br = 1; cycle(s);
        cycle(idle());

        // trap held under im_stall, then accepted once
        s = idle(); s.trap = 1; s.ims = 1;
        repeat (3) cycle(s);
        s.ims = 0; cycle(s);
        cycle(idle());

        // accumulate some stalls, then reset mid-drain
        s = idle(); s.vld = 1; s.ld = 1; s.wa = 7; s.rs2 = 7; s.u2 = 1;
        repeat (4) cycle(s);
        s = idle(); s.vld = 1; s.csr = 1;
        cycle(s); cycle(s);
        s.rst = 1; cycle(s);
        cycle(idle());

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 199) == 0);
            s.vld  = ($urandom_range(0, 9) < 8);
            s.csr  = ($urandom_range(0, 9) < 2);
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.u1   = 1'($urandom);
            s.u2   = 1'($urandom);
            s.f1   = ($urandom_range(0, 3) == 0);
            s.f2   = ($urandom_range(0, 3) == 0);
            s.ld   = 1'($urandom);
            s.wa   = 5'($urandom_range(0, 3));
            s.df   = ($urandom_range(0, 3) == 0);
            s.br   = ($urandom_range(0, 11) == 0);
            s.trap = ($urandom_range(0, 19) == 0);
            s.ims  = ($urandom_range(0, 7) == 0);
            s.dms  = ($urandom_range(0, 7) == 0);
            cycle(s);
        end
        cycle(idle());

        // bounded wait for the monitor to consume everything
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
